hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage CPU. Decides each cycle whether IF/ID
//  and the PC hold (stall), the IF/ID and ID/EX latches are squashed (flush/bubble),
//  or the pipe advances. Sources: load-use hazards, taken branches/jumps, and the
//  multi-cycle mult/div unit. Drives Load_Use on the IF/ID segment and PC write enable.
// PARAMETERS
//  MD_LAT    default 8   cycles from md_start until the HI/LO result is valid (2..255)
//  CNT_W     default 16  width of the performance counters
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  id_rs          in   5      rs field of the instruction in ID
//  id_rt          in   5      rt field of the instruction in ID
//  id_use_rs      in   1      ID instruction reads rs
//  id_use_rt      in   1      ID instruction reads rt
//  id_md_read     in   1      ID instruction is mfhi/mflo
//  id_md_start    in   1      ID instruction is mult/multu/div/divu
//  id_jump        in   1      j/jal/jr resolved in ID
//  ex_memread     in   1      instruction in EX is a load
//  ex_rt          in   5      destination of the load in EX
//  ex_br_taken    in   1      branch in EX resolved taken
//  Load_Use       out  1      hold IF/ID (1 = hold)
//  pc_write       out  1      PC update enable
//  ifid_flush     out  1      clear IF/ID to nop at next edge
//  idex_bubble    out  1      insert nop into ID/EX at next edge
//  md_busy        out  1      mult/div operation in flight
//  stall_cnt      out  CNT_W  cycles with Load_Use=1 (saturating)
//  flush_cnt      out  CNT_W  cycles with ifid_flush=1 (saturating)
// BEHAVIOUR
//  Hazard terms (combinational, same cycle):
//   lu    = ex_memread & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt))
//   mdh   = md_busy & (id_md_read | id_md_start)
//   stall = lu | mdh
//  Priority: ex_br_taken > stall > id_jump.
//   ex_br_taken: ifid_flush=1, idex_bubble=1, Load_Use=0, pc_write=1; stall ignored.
//   stall (no ex_br_taken): Load_Use=1, pc_write=0, idex_bubble=1, ifid_flush=0.
//   id_jump (neither): ifid_flush=1, pc_write=1, Load_Use=0, idex_bubble=0.
//   none: pc_write=1; all other control outputs 0.
//  Mult/div FSM (registered): states IDLE, BUSY.
//   IDLE->BUSY when id_md_start & ~stall & ~ex_br_taken; md_cnt <= MD_LAT-1.
//   BUSY: md_cnt decrements each cycle; BUSY->IDLE when md_cnt==0 at the edge.
//   md_busy = (state==BUSY); cleared on the edge where md_cnt==0, so a dependent
//   mfhi stalls exactly MD_LAT cycles after the mult leaves ID.
//   ex_br_taken while BUSY does not abort the op (mult issued before branch).
//   id_md_start squashed by ex_br_taken in the same cycle does not start the FSM.
//  Counters: stall_cnt +1 on each posedge with Load_Use=1; flush_cnt +1 on each
//   posedge with ifid_flush=1; both saturate at all-ones.
//  Reset (rst=1 at posedge): state=IDLE, md_cnt=0, stall_cnt=0, flush_cnt=0.
//   Outputs during and after reset: md_busy=0, Load_Use=0, pc_write=1,
//   ifid_flush=0, idex_bubble=0 unless hazard inputs are active.
//   rst in BUSY aborts the op: IDLE and md_busy=0 on the next cycle.
//  Register $0 never causes a load-use stall.
// TESTING
//  1 lw $5 in EX, ID add $6,$5,$7 -> one cycle Load_Use=1, pc_write=0, idex_bubble=1; stall_cnt=1
//  2 lw $0 in EX, ID reads $0 -> no stall; lw $5 in EX + ex_br_taken -> flush only, Load_Use=0
//  3 mult issued, mfhi next, MD_LAT=8 -> Load_Use high 8 cycles, md_busy falls with stall
//  4 id_jump for 1 cycle -> ifid_flush=1, pc_write=1 that cycle; flush_cnt=1
//  5 rst at 3rd BUSY cycle -> md_busy=0 next cycle, counters=0, mfhi in ID not stalled
//  6 force stall_cnt to 16'hFFFE, 3 stall cycles -> stall_cnt holds 16'hFFFF

Source files
------------

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: resolves load-use, mult/div and control hazards into
// hold/flush/bubble controls for the 5-stage pipe, with saturating event counters.
module hazard_sched #(
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_md_read,
    input  logic             id_md_start,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_br_taken,
    output logic             Load_Use,
    output logic             pc_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    md_state_e        state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu, mdh, stall;

    assign md_busy   = (state_q == BUSY);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        lu = ex_memread && (ex_rt != 5'd0) &&
             ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
        mdh   = md_busy && (id_md_read || id_md_start);
        stall = lu || mdh;

        Load_Use    = 1'b0;
        pc_write    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            Load_Use    = 1'b1;
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            IDLE: begin
                // A start squashed by a taken branch or held by a stall never issues.
                if (id_md_start && !stall && !ex_br_taken) begin
                    state_d  = BUSY;
                    md_cnt_d = 8'(MD_LAT - 1);
                end
            end
            BUSY: begin
                if (md_cnt_q == 8'd0) state_d  = IDLE;
                else                  md_cnt_d = md_cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Load_Use && (stall_cnt_q != CNT_MAX))  stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: table-driven combinational vectors plus
// directed sequences for mult/div latency, squash, reset abort and counter saturation.
module tb_hazard_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rs, id_use_rt, id_md_read, id_md_start, id_jump;
    logic        ex_memread, ex_br_taken;
    logic        Load_Use, pc_write, ifid_flush, idex_bubble, md_busy;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_sched #(.MD_LAT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_md_read(id_md_read), .id_md_start(id_md_start), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
        .Load_Use(Load_Use), .pc_write(pc_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       jump;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       e_lu;
        logic       e_pcw;
        logic       e_fl;
        logic       e_bub;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_md_read = 1'b0; id_md_start = 1'b0; id_jump = 1'b0;
        ex_memread = 1'b0; ex_br_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic lu, input logic pcw,
                              input logic fl, input logic bub);
        check({tag, ".Load_Use"},    {31'd0, Load_Use},    {31'd0, lu});
        check({tag, ".pc_write"},    {31'd0, pc_write},    {31'd0, pcw});
        check({tag, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, fl});
        check({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, bub});
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, exp_stall);
        check({tag, ".flush_cnt"}, {16'd0, flush_cnt}, exp_flush);
    endtask

    initial begin
        //           rs     rt     urs   urt   jmp   mrd   ex_rt  br    lu    pcw   fl    bub
        vecs[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{5'd9, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        check_ctrl("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset.md_busy", {31'd0, md_busy}, 32'd0);
        check_counters("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            id_rs = vecs[i].rs;        id_rt = vecs[i].rt;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            id_jump = vecs[i].jump;    ex_memread = vecs[i].memread;
            ex_rt = vecs[i].ex_rt;     ex_br_taken = vecs[i].br;
            #2;
            check_ctrl($sformatf("vec%0d", i), vecs[i].e_lu, vecs[i].e_pcw,
                       vecs[i].e_fl, vecs[i].e_bub);
            next_cycle();
            exp_stall += int'(vecs[i].e_lu);
            exp_flush += int'(vecs[i].e_fl);
            check_counters($sformatf("vec%0d", i));
        end

        // mult issues, dependent mfhi follows and must hold exactly MD_LAT cycles
        clear_inputs();
        id_md_start = 1'b1;
        #2;
        check_ctrl("mult_issue", 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        clear_inputs();
        id_md_read = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #2;
            check($sformatf("mfhi_wait%0d.md_busy", c), {31'd0, md_busy}, 32'd1);
            check_ctrl($sformatf("mfhi_wait%0d", c), 1'b1, 1'b0, 1'b0, 1'b1);
            next_cycle();
            exp_stall++;
        end
        #2;
        check("mfhi_go.md_busy", {31'd0, md_busy}, 32'd0);
        check_ctrl("mfhi_go", 1'b0, 1'b1, 1'b0, 1'b0);
        check_counters("mfhi_go");
        next_cycle();

        // mult squashed by a taken branch in the same cycle never starts
        clear_inputs();
        id_md_start = 1'b1;
        ex_br_taken = 1'b1;
        #2;
        check_ctrl("mult_squash", 1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        exp_flush++;
        clear_inputs();
        #2;
        check("mult_squash.md_busy", {31'd0, md_busy}, 32'd0);
        check_counters("mult_squash");
        next_cycle();

        // reset during the third busy cycle aborts the op and clears counters
        clear_inputs();
        id_md_start = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
        #2;
        check("rst_busy.md_busy_before", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        id_md_read = 1'b1;
        #2;
        check("rst_busy.md_busy_after", {31'd0, md_busy}, 32'd0);
        check_ctrl("rst_busy_mfhi", 1'b0, 1'b1, 1'b0, 1'b0);
        check_counters("rst_busy");
        next_cycle();
        clear_inputs();

        // hold a load-use hazard until stall_cnt reaches 16'hFFFE, then saturate
        id_rs = 5'd5; id_use_rs = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5;
        repeat (65534) @(posedge clk);
        #1;
        exp_stall = 32'hFFFE;
        check_counters("sat_fffe");
        repeat (3) @(posedge clk);
        #1;
        exp_stall = 32'hFFFF;
        #2;
        check_ctrl("sat_hold", 1'b1, 1'b0, 1'b0, 1'b1);
        check_counters("sat_ffff");
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
